// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Sequences the 5-stage MIPS pipeline. It owns the debug execution-mode
//   FSM (IDLE / RUN / STEP / HALTED), detects load-use hazards between EX and
//   ID, and generates the enable / flush / bubble controls for the PC, IF/ID
//   and ID/EX stage registers. It also keeps saturating counters of executed
//   cycles and stall cycles.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_run_req           start continuous execution (level or pulse)
//   i_step_req          advance exactly one clock (pulse)
//   i_halt              HALT instruction has reached WB
//   i_id_rs, i_id_rt    source register fields of the instruction in ID
//   i_id_uses_rt        instruction in ID reads rt as a source
//   i_ex_mem_read       instruction in EX is a load
//   i_ex_rt             destination register of the load in EX
//   i_branch_taken      branch/jump in ID resolved taken
//   o_pipe_en           enable for EX/MEM and MEM/WB registers
//   o_pc_en             PC write enable
//   o_if_id_en          IF/ID write enable
//   o_if_id_flush       IF/ID loads a NOP
//   o_id_ex_bubble      ID/EX loads zeroed control signals
//   o_state             0 IDLE, 1 RUN, 2 STEP, 3 HALTED
//   o_cycle_cnt         cycles with o_pipe_en=1 (saturating)
//   o_stall_cnt         load-use stall cycles (saturating)

module pipeline_ctrl #(
  parameter int NBITS  = 32,
  parameter int NB_REG = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run_req,
  input  logic              i_step_req,
  input  logic              i_halt,
  input  logic [NB_REG-1:0] i_id_rs,
  input  logic [NB_REG-1:0] i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_ex_mem_read,
  input  logic [NB_REG-1:0] i_ex_rt,
  input  logic              i_branch_taken,
  output logic              o_pipe_en,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_bubble,
  output logic [1:0]        o_state,
  output logic [NBITS-1:0]  o_cycle_cnt,
  output logic [NBITS-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               pipe_en;
  logic               stall;
  logic [NBITS-1:0]   cycle_cnt;
  logic [NBITS-1:0]   stall_cnt;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [NBITS-1:0] sat_inc(input logic [NBITS-1:0] v);
    if (&v) return v;
    return v + {{(NBITS-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        // A simultaneous run and step request resolves to RUN.
        if (i_run_req)       state_nxt = ST_RUN;
        else if (i_step_req) state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (i_halt) state_nxt = ST_HALTED;
      end
      ST_STEP: begin
        // A step lasts a single cycle.
        state_nxt = i_halt ? ST_HALTED : ST_IDLE;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign pipe_en = (state == ST_RUN) || (state == ST_STEP);

  // Load-use hazard: the load in EX writes a register the ID instruction
  // reads. Register 0 is hardwired to zero and never creates a dependency.
  assign stall = pipe_en && i_ex_mem_read && (i_ex_rt != '0) &&
                 ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

  always_comb begin
    o_pc_en        = 1'b0;
    o_if_id_en     = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    if (pipe_en) begin
      if (stall) begin
        // Freeze PC and IF/ID, inject a bubble; a taken branch is ignored
        // here and re-resolves once the load result is available.
        o_id_ex_bubble = 1'b1;
      end else begin
        o_pc_en       = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = i_branch_taken;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pipe_en) cycle_cnt <= sat_inc(cycle_cnt);
      if (stall)   stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign o_pipe_en   = pipe_en;
  assign o_state     = state;
  assign o_cycle_cnt = cycle_cnt;
  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req, step_req, halt;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, branch_taken;

  logic        pipe_en, pc_en, if_id_en, if_id_flush, id_ex_bubble;
  logic [1:0]  state;
  logic [31:0] cycle_cnt, stall_cnt;

  logic        pipe_en4, pc_en4, if_id_en4, if_id_flush4, id_ex_bubble4;
  logic [1:0]  state4;
  logic [3:0]  cycle_cnt4, stall_cnt4;

  int total = 0;
  int bad   = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NBITS(32), .NB_REG(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_run_req(run_req), .i_step_req(step_req),
    .i_halt(halt), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_branch_taken(branch_taken),
    .o_pipe_en(pipe_en), .o_pc_en(pc_en), .o_if_id_en(if_id_en),
    .o_if_id_flush(if_id_flush), .o_id_ex_bubble(id_ex_bubble),
    .o_state(state), .o_cycle_cnt(cycle_cnt), .o_stall_cnt(stall_cnt)
  );

  pipeline_ctrl #(.NBITS(4), .NB_REG(5)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_run_req(run_req), .i_step_req(step_req),
    .i_halt(halt), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .i_branch_taken(branch_taken),
    .o_pipe_en(pipe_en4), .o_pc_en(pc_en4), .o_if_id_en(if_id_en4),
    .o_if_id_flush(if_id_flush4), .o_id_ex_bubble(id_ex_bubble4),
    .o_state(state4), .o_cycle_cnt(cycle_cnt4), .o_stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_hazard();
    ex_mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    branch_taken = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; run_req = 0; step_req = 0; halt = 0;
    clr_hazard();
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_pipe_en", pipe_en, 0);
    chk("rst_pc_en", pc_en, 0);
    rst = 0;
    // IDLE: branch and hazard inputs have no effect while not enabled.
    branch_taken = 1; ex_mem_read = 1; ex_rt = 5; id_rs = 5; #1;
    chk("idle_flush", if_id_flush, 0);
    chk("idle_bubble", id_ex_bubble, 0);
    clr_hazard();
    tick();                          // cycle 1

    // Scenario 1: run pulse in cycle 2, halt in cycle 10.
    tick();                          // cycle 2
    run_req = 1; #1;
    chk("s1_state_c2", state, 0);
    tick();                          // cycle 3
    run_req = 0;
    chk("s1_state_c3", state, 1);
    chk("s1_pipe_en", pipe_en, 1);
    chk("s1_pc_en", pc_en, 1);
    chk("s1_if_id_en", if_id_en, 1);
    chk("s1_cycle_c3", cycle_cnt, 0);
    repeat (7) tick();               // cycle 10
    halt = 1;
    chk("s1_cycle_c10", cycle_cnt, 7);
    tick();                          // cycle 11
    halt = 0;
    chk("s1_state_halted", state, 3);
    chk("s1_halt_pipe_en", pipe_en, 0);
    chk("s1_halt_pc_en", pc_en, 0);
    chk("s1_halt_if_id_en", if_id_en, 0);
    chk("s1_cycle_final", cycle_cnt, 8);
    run_req = 1; step_req = 1;
    tick();
    run_req = 0; step_req = 0;
    chk("s1_halted_sticky", state, 3);
    chk("s1_halted_cycle", cycle_cnt, 8);
    rst = 1;
    tick();
    rst = 0;
    chk("s5_rst_halted_state", state, 0);
    chk("s5_rst_halted_cycle", cycle_cnt, 0);

    // Scenario 2: three single-step pulses, 4 cycles apart.
    for (int i = 0; i < 3; i++) begin
      step_req = 1;
      tick();
      step_req = 0;
      chk("s2_step_state", state, 2);
      chk("s2_step_pipe_en", pipe_en, 1);
      tick();
      chk("s2_after_state", state, 0);
      chk("s2_after_pipe_en", pipe_en, 0);
      tick(); tick();
    end
    chk("s2_cycle", cycle_cnt, 3);
    run_req = 1;
    tick();
    run_req = 0;
    chk("s2_run_state", state, 1);
    step_req = 1;
    tick();
    step_req = 0;
    chk("s2_step_in_run", state, 1);

    // Scenario 3: load-use hazard in RUN.
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; #1;
    chk("s3_pc_en", pc_en, 0);
    chk("s3_if_id_en", if_id_en, 0);
    chk("s3_bubble", id_ex_bubble, 1);
    chk("s3_flush", if_id_flush, 0);
    chk("s3_pipe_en", pipe_en, 1);
    tick(); exp_stall++;
    chk("s3_stall_cnt1", stall_cnt, exp_stall);
    ex_rt = 0; id_rs = 0; #1;
    chk("s3_r0_pc_en", pc_en, 1);
    chk("s3_r0_bubble", id_ex_bubble, 0);
    tick();
    chk("s3_r0_stall_cnt", stall_cnt, exp_stall);
    ex_rt = 5; id_rs = 1; id_rt = 5; id_uses_rt = 0; #1;
    chk("s3_nort_pc_en", pc_en, 1);
    chk("s3_nort_bubble", id_ex_bubble, 0);
    id_uses_rt = 1; #1;
    chk("s3_rt_pc_en", pc_en, 0);
    chk("s3_rt_bubble", id_ex_bubble, 1);
    tick(); exp_stall++;
    clr_hazard(); #1;
    chk("s3_stall_cnt2", stall_cnt, exp_stall);

    // Scenario 4: taken branch flushes IF/ID unless stalled.
    branch_taken = 1; #1;
    chk("s4_flush", if_id_flush, 1);
    chk("s4_pc_en", pc_en, 1);
    chk("s4_bubble", id_ex_bubble, 0);
    tick();
    branch_taken = 0; #1;
    chk("s4_flush_off", if_id_flush, 0);
    branch_taken = 1; ex_mem_read = 1; ex_rt = 7; id_rs = 7; #1;
    chk("s4_stall_flush", if_id_flush, 0);
    chk("s4_stall_bubble", id_ex_bubble, 1);
    chk("s4_stall_pc_en", pc_en, 0);

    // Halt coinciding with a stall: both take effect.
    halt = 1;
    tick(); exp_stall++;
    halt = 0; clr_hazard(); #1;
    chk("halt_stall_state", state, 3);
    chk("halt_stall_cnt", stall_cnt, exp_stall);
    rst = 1;
    tick();
    rst = 0;

    // Scenario 5: run+step together in IDLE, then reset mid-RUN.
    run_req = 1; step_req = 1;
    tick();
    run_req = 0; step_req = 0;
    chk("s5_both_state", state, 1);
    tick(); tick();
    chk("s5_cycle_pre", cycle_cnt, 2);
    rst = 1;
    tick();
    rst = 0;
    chk("s5_rst_run_state", state, 0);
    chk("s5_rst_run_cycle", cycle_cnt, 0);
    chk("s5_rst_run_stall", stall_cnt, 0);

    // Scenario 6: 4-bit counter saturates.
    run_req = 1;
    tick();
    run_req = 0;
    repeat (20) tick();
    chk("s6_cycle32", cycle_cnt, 20);
    chk("s6_cycle4_sat", cycle_cnt4, 15);
    tick();
    chk("s6_cycle4_hold", cycle_cnt4, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
